rand_perm: RTL and testbench

- Fisher–Yates shuffler sitting directly downstream of the LFSR.
- Consumes one pseudo-random word per cycle through an `advance` handshake.
- Produces a uniformly shuffled permutation of 0..LEN-1, which seeds Sudoku row/candidate ordering in the generator.
- Bounded rejection sampling with a deterministic fold fallback guarantees termination.

---
 rtl/rand_pkg.sv | 16 +
 rtl/rand_perm.sv | 111 +++++++++++
 tb/tb_rand_perm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - shared types and mask helper for the Fisher-Yates shuffler
package rand_pkg;

  typedef enum logic {IDLE, SHUFFLE} perm_state_t;

  // Smallest all-ones value >= i, i.e. 2^clog2(i+1)-1
  function automatic logic [4:0] mask_for(input logic [4:0] i);
    logic [4:0] m;
    m = '0;
    for (int b = 0; b < 5; b++) begin
      if (m < i) m = {m[3:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/rand_perm.sv
// rtl/rand_perm.sv - Fisher-Yates shuffler consuming one random word per cycle
module rand_perm
  import rand_pkg::*;
#(
  parameter int LEN        = 9,
  parameter int RAND_WIDTH = 8,
  parameter int RETRY_MAX  = 4,
  localparam int ELEM_W    = $clog2(LEN)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [RAND_WIDTH-1:0]   rand_in,
  output logic                    rand_advance,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [LEN*ELEM_W-1:0]   perm_out
);

  localparam int TRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [ELEM_W-1:0] LAST = ELEM_W'(LEN - 1);

  perm_state_t       state_q, state_d;
  logic [ELEM_W-1:0] perm_q [LEN];
  logic [ELEM_W-1:0] perm_d [LEN];
  logic [ELEM_W-1:0] i_q, i_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic [ELEM_W-1:0]     mask;
  logic [RAND_WIDTH-1:0] cand_full;
  logic [ELEM_W-1:0]     cand;
  logic [ELEM_W-1:0]     j;
  logic                  in_range;
  logic                  take;

  always_comb begin
    mask      = ELEM_W'(mask_for(5'(i_q)));
    cand_full = rand_in & RAND_WIDTH'(mask);
    cand      = cand_full[ELEM_W-1:0];
    in_range  = cand_full <= RAND_WIDTH'(i_q);
    take      = in_range || (tries_q == TRY_W'(RETRY_MAX));
    // Fold: cand lies in i+1..mask <= 2i+1, so cand-(i+1) lands in 0..i
    j         = in_range ? cand : cand - i_q - ELEM_W'(1);

    state_d = state_q;
    perm_d  = perm_q;
    i_d     = i_q;
    tries_d = tries_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < LEN; k++) perm_d[k] = ELEM_W'(k);
          i_d     = LAST;
          tries_d = '0;
          valid_d = 1'b0;
          state_d = SHUFFLE;
        end
      end
      SHUFFLE: begin
        if (take) begin
          perm_d[i_q] = perm_q[j];
          perm_d[j]   = perm_q[i_q];
          tries_d     = '0;
          if (i_q == ELEM_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            i_d = i_q - ELEM_W'(1);
          end
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int k = 0; k < LEN; k++) perm_q[k] <= ELEM_W'(k);
      i_q     <= LAST;
      tries_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      perm_q  <= perm_d;
      i_q     <= i_d;
      tries_q <= tries_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign busy         = (state_q == SHUFFLE);
  assign rand_advance = (state_q == SHUFFLE);
  assign done         = done_q;
  assign valid        = valid_q;

  for (genvar g = 0; g < LEN; g++) begin : g_pack
    assign perm_out[g*ELEM_W +: ELEM_W] = perm_q[g];
  end

endmodule

// File: tb/tb_rand_perm.sv
// tb/tb_rand_perm.sv - self-checking bench for rand_perm at LEN 2, 4 and 9
module tb_rand_perm;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  rand_w;

  logic        adv_2, busy_2, done_2, valid_2;
  logic [1:0]  perm_2;
  logic        adv_4, busy_4, done_4, valid_4;
  logic [7:0]  perm_4;
  logic        adv_9, busy_9, done_9, valid_9;
  logic [35:0] perm_9;

  always #5 clk = ~clk;

  rand_perm #(.LEN(2), .RAND_WIDTH(8), .RETRY_MAX(4)) u2 (
    .clock(clk), .reset(rstn), .start(start), .rand_in(rand_w),
    .rand_advance(adv_2), .busy(busy_2), .done(done_2), .valid(valid_2), .perm_out(perm_2));
  rand_perm #(.LEN(4), .RAND_WIDTH(8), .RETRY_MAX(4)) u4 (
    .clock(clk), .reset(rstn), .start(start), .rand_in(rand_w),
    .rand_advance(adv_4), .busy(busy_4), .done(done_4), .valid(valid_4), .perm_out(perm_4));
  rand_perm #(.LEN(9), .RAND_WIDTH(8), .RETRY_MAX(4)) u9 (
    .clock(clk), .reset(rstn), .start(start), .rand_in(rand_w),
    .rand_advance(adv_9), .busy(busy_9), .done(done_9), .valid(valid_9), .perm_out(perm_9));

  int checks = 0;
  int errors = 0;
  int sel = 9;

  logic        adv_s, busy_s, done_s, valid_s;
  logic [63:0] perm_s;

  always_comb begin
    adv_s = adv_9; busy_s = busy_9; done_s = done_9; valid_s = valid_9; perm_s = 64'(perm_9);
    if (sel == 4) begin
      adv_s = adv_4; busy_s = busy_4; done_s = done_4; valid_s = valid_4; perm_s = 64'(perm_4);
    end else if (sel == 2) begin
      adv_s = adv_2; busy_s = busy_2; done_s = done_2; valid_s = valid_2; perm_s = 64'(perm_2);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int elem_w(input int len);
    int ew = 0;
    while ((1 << ew) < len) ew++;
    return ew;
  endfunction

  // Reference: textbook Fisher-Yates with bounded rejection, walking the word list
  task automatic model(input int len, input int w[64], output logic [63:0] pk, output int cyc);
    int p[16];
    int k, ew, m, c, j, tries, tmp;
    bit got;
    k  = 0;
    ew = elem_w(len);
    for (int e = 0; e < len; e++) p[e] = e;
    for (int i = len - 1; i >= 1; i--) begin
      tries = 0;
      got   = 0;
      j     = 0;
      while (!got && k < 64) begin
        m = 1;
        while (m < i + 1) m = m * 2;
        c = w[k] & (m - 1);
        k++;
        if (c <= i) begin j = c; got = 1; end
        else if (tries == 4) begin j = c - (i + 1); got = 1; end
        else tries++;
      end
      tmp = p[i]; p[i] = p[j]; p[j] = tmp;
    end
    cyc = k;
    pk  = '0;
    for (int e = 0; e < len; e++) pk = pk | (64'(p[e]) << (e * ew));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_2 || busy_4 || busy_9) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 64'(n), 64'(0));
  endtask

  task automatic run_shuffle(input int which, input int w[64],
                             output int cyc, output int adv_cnt, output int busy_cnt);
    int k = 0;
    wait_idle();
    sel      = which;
    adv_cnt  = 0;
    busy_cnt = 0;
    start    = 1'b1;
    rand_w   = 8'h00;
    @(negedge clk);
    start = 1'b0;
    while (!done_s && k < 64) begin
      if (adv_s)  adv_cnt++;
      if (busy_s) busy_cnt++;
      rand_w = 8'(w[k]);
      k++;
      @(negedge clk);
    end
    if (!done_s) chk("done_timeout", 64'(k), 64'(0));
    cyc = k;
  endtask

  typedef struct {
    int          len;
    logic [7:0]  word;
    logic [63:0] exp_perm;
    int          exp_cyc;
  } vec_t;

  vec_t        tbl[6];
  int          words[64];
  int          cyc, adv_cnt, busy_cnt, exp_cyc, ew;
  logic [63:0] exp_pk, id9;
  logic [9:0]  rec_d, rec_v, rec_b;
  logic [8:0]  seen;
  logic [7:0]  lfsr, tmp;
  int          done_seen;

  initial begin
    tbl[0] = '{4, 8'h00, 64'h39, 3};
    tbl[1] = '{4, 8'hFF, 64'hC6, 7};
    tbl[2] = '{4, 8'h02, 64'hB1, 3};
    tbl[3] = '{4, 8'h01, 64'h78, 3};
    tbl[4] = '{2, 8'h01, 64'h2,  1};
    tbl[5] = '{2, 8'h00, 64'h1,  1};

    id9 = '0;
    for (int e = 0; e < 9; e++) id9 = id9 | (64'(e) << (e * 4));

    rstn   = 1'b0;
    start  = 1'b0;
    rand_w = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'({busy_2, busy_4, busy_9}), 64'(0));
    chk("rst_adv",   64'({adv_2, adv_4, adv_9}), 64'(0));
    chk("rst_done",  64'({done_2, done_4, done_9}), 64'(0));
    chk("rst_valid", 64'({valid_2, valid_4, valid_9}), 64'(0));
    chk("rst_perm9", 64'(perm_9), id9);
    chk("rst_perm4", 64'(perm_4), 64'h E4);
    rstn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 64; k++) words[k] = int'(tbl[t].word);
      run_shuffle(tbl[t].len, words, cyc, adv_cnt, busy_cnt);
      chk($sformatf("tbl%0d_perm", t), perm_s, tbl[t].exp_perm);
      chk($sformatf("tbl%0d_cyc", t), 64'(cyc), 64'(tbl[t].exp_cyc));
      chk($sformatf("tbl%0d_adv", t), 64'(adv_cnt), 64'(tbl[t].exp_cyc));
      chk($sformatf("tbl%0d_valid", t), 64'(valid_s), 64'(1));
    end

    // start held high across two back-to-back shuffles on LEN=4
    wait_idle();
    rand_w = 8'h00;
    start  = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      rec_d[n-1] = done_4;
      rec_v[n-1] = valid_4;
      rec_b[n-1] = busy_4;
      if (n == 8) start = 1'b0;
    end
    chk("hold_done",  64'(rec_d), 64'(10'b0010001000));
    chk("hold_valid", 64'(rec_v), 64'(10'b1110001000));
    chk("hold_busy",  64'(rec_b), 64'(10'b0001110111));
    chk("hold_perm",  64'(perm_4), 64'h39);

    // reset on the second SHUFFLE cycle of LEN=9
    wait_idle();
    rand_w    = 8'h00;
    start     = 1'b1;
    done_seen = 0;
    @(negedge clk);
    start = 1'b0;
    if (done_9) done_seen++;
    @(negedge clk);
    if (done_9) done_seen++;
    rstn = 1'b0;
    @(negedge clk);
    if (done_9) done_seen++;
    chk("mid_rst_busy",  64'(busy_9), 64'(0));
    chk("mid_rst_valid", 64'(valid_9), 64'(0));
    chk("mid_rst_perm",  64'(perm_9), id9);
    rstn = 1'b1;
    @(negedge clk);
    if (done_9) done_seen++;
    chk("mid_rst_nodone", 64'(done_seen), 64'(0));
    for (int k = 0; k < 64; k++) words[k] = 0;
    model(9, words, exp_pk, exp_cyc);
    run_shuffle(9, words, cyc, adv_cnt, busy_cnt);
    chk("after_rst_perm", perm_s, exp_pk);
    chk("after_rst_cyc",  64'(cyc), 64'(exp_cyc));

    // 200 shuffles: first half from an 8-bit LFSR stream, second half from $urandom
    lfsr = 8'h01;
    ew   = elem_w(9);
    for (int s = 0; s < 200; s++) begin
      tmp = lfsr;
      for (int k = 0; k < 64; k++) begin
        if (s < 100) begin
          words[k] = int'(tmp);
          tmp = {tmp[6:0], ^(tmp & 8'b10111000)};
        end else begin
          words[k] = int'($urandom_range(255, 0));
        end
      end
      model(9, words, exp_pk, exp_cyc);
      run_shuffle(9, words, cyc, adv_cnt, busy_cnt);
      if (s < 100) begin
        for (int k = 0; k < exp_cyc; k++) lfsr = {lfsr[6:0], ^(lfsr & 8'b10111000)};
      end
      seen = '0;
      for (int e = 0; e < 9; e++) seen[4'(perm_s >> (e * ew))] = 1'b1;
      chk($sformatf("rnd%0d_perm", s), perm_s, exp_pk);
      chk($sformatf("rnd%0d_cyc", s), 64'(cyc), 64'(exp_cyc));
      chk($sformatf("rnd%0d_adv", s), 64'(adv_cnt), 64'(exp_cyc));
      chk($sformatf("rnd%0d_busy", s), 64'(busy_cnt), 64'(adv_cnt));
      chk($sformatf("rnd%0d_range", s), 64'(cyc >= 8 && cyc <= 40), 64'(1));
      chk($sformatf("rnd%0d_unique", s), 64'(seen), 64'(9'h1FF));
      chk($sformatf("rnd%0d_valid", s), 64'(valid_9), 64'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
